// File: rtl/tcdm_resp_pkg.sv
// -----------------------------------------------------------------------------
// tcdm_resp_pkg
// Shared types and constants for the TCDM SRAM responder.
//   tcdm_resp_t     : one response entry {valid, rdata, opc}
//   TCDM_OPC_OK/ERR : values of the response opcode (error = out of range)
//   MAX_LATENCY     : largest supported grant-to-response latency
//   MAX_WAIT_STATES : largest supported wait-state count (4-bit counter)
// -----------------------------------------------------------------------------
package tcdm_resp_pkg;

    localparam int MAX_LATENCY     = 4;
    localparam int MAX_WAIT_STATES = 15;

    localparam logic TCDM_OPC_OK  = 1'b0;
    localparam logic TCDM_OPC_ERR = 1'b1;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        opc;
    } tcdm_resp_t;

endpackage

// File: rtl/tcdm_resp_delay_line.sv
// -----------------------------------------------------------------------------
// tcdm_resp_delay_line
// Fixed-depth shift register of response entries. An entry presented on in_i
// appears on out_o LATENCY clocks later. Reset clears every stage, so no
// in-flight response survives a reset and idle outputs read as all zero.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   in_i   : entry entering the line
//   out_o  : entry leaving the line
// -----------------------------------------------------------------------------
module tcdm_resp_delay_line
    import tcdm_resp_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  tcdm_resp_t in_i,
    output tcdm_resp_t out_o
);

    if (LATENCY < 1) begin : g_bad_depth
        $error("tcdm_resp_delay_line: LATENCY must be at least 1");
    end

    tcdm_resp_t stage_reg [LATENCY];

    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
        tcdm_resp_t stage_next;

        if (gi == 0) begin : g_head
            assign stage_next = in_i;
        end else begin : g_tail
            assign stage_next = stage_reg[gi-1];
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                stage_reg[gi] <= '0;
            end else begin
                stage_reg[gi] <= stage_next;
            end
        end
    end

    assign out_o = stage_reg[LATENCY-1];

endmodule

// File: rtl/tcdm_sram_responder.sv
// -----------------------------------------------------------------------------
// tcdm_sram_responder
// TCDM slave port in front of a byte-enabled word memory. Grants after a
// programmable number of wait states and returns one response per grant a
// fixed LATENCY cycles after the grant edge, in grant order.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_i        : request valid (held with its payload until granted)
//   add_i        : byte address, bits [1:0] ignored
//   wen_i        : 1 = read, 0 = write
//   wdata_i/be_i : write data and byte enables
//   gnt_o        : request accepted this cycle (combinational)
//   r_valid_o    : response valid, one cycle per grant
//   r_rdata_o    : read data, 0 for writes and errors
//   r_opc_o      : 1 = address out of range
// -----------------------------------------------------------------------------
module tcdm_sram_responder
    import tcdm_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1C00_0000,
    parameter int          MEM_WORDS   = 1024,
    parameter int          LATENCY     = 1,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [31:0] add_i,
    input  logic        wen_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        gnt_o,
    output logic        r_valid_o,
    output logic [31:0] r_rdata_o,
    output logic        r_opc_o
);

    localparam int AW = $clog2(MEM_WORDS);
    // One bit wider than the address so a window ending at 4 GiB cannot wrap.
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * MEM_WORDS);

    if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
        $error("tcdm_sram_responder: LATENCY out of range 1..4");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT_STATES) begin : g_bad_wait
        $error("tcdm_sram_responder: WAIT_STATES out of range 0..15");
    end
    if (MEM_WORDS < 4 || (1 << AW) != MEM_WORDS) begin : g_bad_words
        $error("tcdm_sram_responder: MEM_WORDS must be a power of two >= 4");
    end

    // ---------------------------------------------------------------- handshake
    logic [3:0] ws_cnt_reg;
    logic       gnt;

    // Gated by reset so nothing is accepted or written while rst_i is high.
    assign gnt   = req_i && !rst_i && (ws_cnt_reg == 4'(WAIT_STATES));
    assign gnt_o = gnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || !req_i || gnt) begin
            ws_cnt_reg <= '0;
        end else begin
            ws_cnt_reg <= ws_cnt_reg + 4'd1;
        end
    end

    // ----------------------------------------------------------- address decode
    logic          hit;
    logic [AW-1:0] idx;

    assign hit = ({1'b0, add_i} >= {1'b0, BASE_ADDR}) && ({1'b0, add_i} < END_ADDR);
    assign idx = AW'((add_i - BASE_ADDR) >> 2);

    // ------------------------------------------------------------------ memory
    logic [31:0] mem [MEM_WORDS];
    logic [31:0] rd_data_reg;
    logic        wr_en;

    assign wr_en = gnt && !wen_i && hit;

    // Unconditional registered read keeps the array mappable to block RAM;
    // the head stage below decides whether the word is actually returned.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        rd_data_reg <= mem[idx];
    end

    // -------------------------------------------------------------- head stage
    // First cycle of the latency: captured alongside the RAM read register.
    logic       head_valid_reg;
    logic       head_read_reg;
    logic       head_opc_reg;
    tcdm_resp_t head_resp;
    tcdm_resp_t tail_resp;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_valid_reg <= 1'b0;
            head_read_reg  <= 1'b0;
            head_opc_reg   <= TCDM_OPC_OK;
        end else begin
            head_valid_reg <= gnt;
            head_read_reg  <= gnt && wen_i && hit;
            head_opc_reg   <= (gnt && !hit) ? TCDM_OPC_ERR : TCDM_OPC_OK;
        end
    end

    always_comb begin
        head_resp       = '0;
        head_resp.valid = head_valid_reg;
        head_resp.rdata = head_read_reg ? rd_data_reg : 32'h0;
        head_resp.opc   = head_opc_reg;
    end

    // Remaining LATENCY-1 cycles of delay.
    if (LATENCY > 1) begin : g_delay
        tcdm_resp_delay_line #(
            .LATENCY (LATENCY - 1)
        ) u_delay_line (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .in_i  (head_resp),
            .out_o (tail_resp)
        );
    end else begin : g_no_delay
        assign tail_resp = head_resp;
    end

    assign r_valid_o = tail_resp.valid;
    assign r_rdata_o = tail_resp.rdata;
    assign r_opc_o   = tail_resp.opc;

endmodule

// File: tb/tb_tcdm_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_tcdm_sram_responder
// Four responder instances with different timing parameters share one clock:
//   0: WAIT_STATES=0 LATENCY=1  basic write/read, byte enables, range errors
//   1: WAIT_STATES=3 LATENCY=4  wait states and back-to-back grants
//   2: WAIT_STATES=0 LATENCY=3  reset while responses are in flight
//   3: WAIT_STATES=0 LATENCY=2  random stream against a reference model
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Cycle k is the interval between rising edges k and k+1.
// -----------------------------------------------------------------------------
module tb_tcdm_sram_responder;

    localparam logic [31:0] BASE = 32'h1C00_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [4];
    logic        req   [4];
    logic [31:0] add   [4];
    logic        wen   [4];
    logic [31:0] wdata [4];
    logic [3:0]  be    [4];
    logic        gnt   [4];
    logic        rv    [4];
    logic [31:0] rdata [4];
    logic        opc   [4];

    tcdm_sram_responder #(.BASE_ADDR(BASE), .MEM_WORDS(1024), .LATENCY(1), .WAIT_STATES(0)) u_a (
        .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .add_i(add[0]), .wen_i(wen[0]),
        .wdata_i(wdata[0]), .be_i(be[0]), .gnt_o(gnt[0]), .r_valid_o(rv[0]),
        .r_rdata_o(rdata[0]), .r_opc_o(opc[0]));

    tcdm_sram_responder #(.BASE_ADDR(BASE), .MEM_WORDS(1024), .LATENCY(4), .WAIT_STATES(3)) u_b (
        .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .add_i(add[1]), .wen_i(wen[1]),
        .wdata_i(wdata[1]), .be_i(be[1]), .gnt_o(gnt[1]), .r_valid_o(rv[1]),
        .r_rdata_o(rdata[1]), .r_opc_o(opc[1]));

    tcdm_sram_responder #(.BASE_ADDR(BASE), .MEM_WORDS(1024), .LATENCY(3), .WAIT_STATES(0)) u_c (
        .clk_i(clk), .rst_i(rst[2]), .req_i(req[2]), .add_i(add[2]), .wen_i(wen[2]),
        .wdata_i(wdata[2]), .be_i(be[2]), .gnt_o(gnt[2]), .r_valid_o(rv[2]),
        .r_rdata_o(rdata[2]), .r_opc_o(opc[2]));

    tcdm_sram_responder #(.BASE_ADDR(BASE), .MEM_WORDS(1024), .LATENCY(2), .WAIT_STATES(0)) u_d (
        .clk_i(clk), .rst_i(rst[3]), .req_i(req[3]), .add_i(add[3]), .wen_i(wen[3]),
        .wdata_i(wdata[3]), .be_i(be[3]), .gnt_o(gnt[3]), .r_valid_o(rv[3]),
        .r_rdata_o(rdata[3]), .r_opc_o(opc[3]));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        opc;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] mdl [1024];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Single non-overlapping access on instance 0 (LATENCY 1): grant in the
    // issue cycle, response in the following cycle.
    task automatic acc0(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        input logic [31:0] exp_rd, input logic exp_opc);
        tick();
        req[0] = 1'b1; wen[0] = w; add[0] = a; wdata[0] = d; be[0] = b;
        sample();
        check({tag, "_gnt"}, gnt[0], 1);
        tick();
        req[0] = 1'b0;
        sample();
        check({tag, "_rv"}, rv[0], 1);
        check({tag, "_rdata"}, rdata[0], exp_rd);
        check({tag, "_opc"}, opc[0], exp_opc);
        $display("txn a %s %s addr=%h rdata=%h opc=%0d", tag, w ? "rd" : "wr", a, rdata[0], opc[0]);
    endtask

    function automatic logic in_range(input logic [31:0] a);
        return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < {1'b0, BASE} + 33'h1000);
    endfunction

    initial begin
        int          gk;
        int          lat;
        int          ops;
        int          grants;
        int          rvs;
        logic [31:0] got;
        logic        issue;

        for (int i = 0; i < 4; i++) begin
            rst[i] = 1'b1; req[i] = 1'b0; add[i] = '0; wen[i] = 1'b1; wdata[i] = '0; be[i] = '0;
        end
        // A request held through reset must never be granted.
        req[0] = 1'b1; add[0] = BASE + 32'h10;

        // ---------------------------------------------------------- reset
        repeat (3) tick();
        sample();
        check("rst_gnt_gated", gnt[0], 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_rv_%0d", i), rv[i], 0);
            check($sformatf("rst_rdata_%0d", i), rdata[i], 0);
            check($sformatf("rst_opc_%0d", i), opc[i], 0);
        end
        tick();
        for (int i = 0; i < 4; i++) rst[i] = 1'b0;
        req[0] = 1'b0;
        sample();
        check("post_rst_rv", rv[0], 0);

        // ---------------------------------- write then read, back to back
        tick();
        req[0] = 1'b1; wen[0] = 1'b0; add[0] = BASE + 32'h10; wdata[0] = 32'hDEAD_BEEF; be[0] = 4'hF;
        sample();
        check("b2b_wr_gnt", gnt[0], 1);
        check("b2b_wr_rv_early", rv[0], 0);
        tick();
        wen[0] = 1'b1;
        sample();
        check("b2b_rd_gnt", gnt[0], 1);
        check("b2b_wr_rv", rv[0], 1);
        check("b2b_wr_rdata", rdata[0], 0);
        check("b2b_wr_opc", opc[0], 0);
        tick();
        req[0] = 1'b0;
        sample();
        check("b2b_rd_rv", rv[0], 1);
        check("b2b_rd_rdata", rdata[0], 32'hDEAD_BEEF);
        check("b2b_rd_opc", opc[0], 0);
        tick();
        sample();
        check("b2b_idle_rv", rv[0], 0);

        // ------------------------------------------------------ byte enables
        acc0("be_init", 1'b0, BASE + 32'h20, 32'hAABB_CCDD, 4'hF, 32'h0, 1'b0);
        acc0("be_part", 1'b0, BASE + 32'h20, 32'h1122_3344, 4'b0101, 32'h0, 1'b0);
        acc0("be_read", 1'b1, BASE + 32'h20, 32'h0, 4'h0, 32'hAA22_CC44, 1'b0);

        // ----------------------------------------------------- out of range
        acc0("top_init", 1'b0, BASE + 32'hFFC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
        acc0("w0_init", 1'b0, BASE, 32'h0123_4567, 4'hF, 32'h0, 1'b0);
        acc0("oor_read", 1'b1, BASE + 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1);
        acc0("oor_write", 1'b0, BASE - 32'h4, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
        acc0("oor_top_kept", 1'b1, BASE + 32'hFFC, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
        acc0("oor_w0_kept", 1'b1, BASE, 32'h0, 4'h0, 32'h0123_4567, 1'b0);
        acc0("oor_w4_kept", 1'b1, BASE + 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

        // ------------------------------------------------------ wait states
        wen[1] = 1'b0; add[1] = BASE + 32'h40; be[1] = 4'hF;
        for (int cyc = 0; cyc < 22; cyc++) begin
            tick();
            req[1]   = (cyc < 16);
            wdata[1] = 32'h1000_0000 + 32'(cyc / 4);
            sample();
            check($sformatf("ws_gnt_c%0d", cyc), gnt[1], (cyc < 16) && (cyc % 4 == 3));
            check($sformatf("ws_rv_c%0d", cyc), rv[1], (cyc >= 7) && (cyc <= 19) && ((cyc - 7) % 4 == 0));
            if (rv[1]) $display("txn b wr resp cyc=%0d opc=%0d", cyc, opc[1]);
        end
        tick();
        req[1] = 1'b1; wen[1] = 1'b1;
        gk = -1;
        for (int k = 0; k < 8 && gk < 0; k++) begin
            if (k > 0) tick();
            sample();
            if (gnt[1]) gk = k;
        end
        check("ws_rd_gnt_cycle", 32'(gk), 3);
        tick();
        req[1] = 1'b0;
        lat = -1; got = 'x;
        for (int k = 1; k <= 8 && lat < 0; k++) begin
            sample();
            if (rv[1]) begin
                lat = k; got = rdata[1];
            end else begin
                tick();
            end
        end
        check("ws_rd_latency", 32'(lat), 4);
        check("ws_rd_rdata", got, 32'h1000_0003);
        $display("txn b rd addr=%h rdata=%h latency=%0d", add[1], got, lat);

        // ------------------------------------------------- reset mid-flight
        tick();
        req[2] = 1'b1; wen[2] = 1'b0; be[2] = 4'hF; add[2] = BASE + 32'h80; wdata[2] = 32'h55AA_00FF;
        tick();
        add[2] = BASE + 32'h84; wdata[2] = 32'h0F0F_0F0F;
        tick();
        req[2] = 1'b0;
        repeat (5) tick();
        req[2] = 1'b1; wen[2] = 1'b1; add[2] = BASE + 32'h80;
        sample();
        check("mf_gnt_c0", gnt[2], 1);
        tick();
        add[2] = BASE + 32'h84;
        sample();
        check("mf_gnt_c1", gnt[2], 1);
        tick();
        rst[2] = 1'b1;
        sample();
        check("mf_gnt_in_rst", gnt[2], 0);
        check("mf_rv_in_rst", rv[2], 0);
        tick();
        rst[2] = 1'b0; req[2] = 1'b0;
        for (int cyc = 3; cyc < 10; cyc++) begin
            sample();
            check($sformatf("mf_rv_c%0d", cyc), rv[2], 0);
            check($sformatf("mf_rdata_c%0d", cyc), rdata[2], 0);
            check($sformatf("mf_opc_c%0d", cyc), opc[2], 0);
            tick();
        end
        req[2] = 1'b1; add[2] = BASE + 32'h84;
        sample();
        check("mf_recover_gnt", gnt[2], 1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            req[2] = 1'b0;
            sample();
            check($sformatf("mf_recover_rv_%0d", k), rv[2], (k == 3));
        end
        check("mf_recover_rdata", rdata[2], 32'h0F0F_0F0F);
        $display("txn c rd addr=%h rdata=%h", add[2], rdata[2]);

        // --------------------------------------------------------- streaming
        ops = 0; grants = 0; rvs = 0;
        for (int cyc = 0; cyc < 600 && (ops < 80 || exp_q.size() > 0); cyc++) begin
            tick();
            issue  = (ops < 80) && ($urandom_range(3) != 0);
            req[3] = issue;
            if (issue) begin
                int          k;
                int          sel;
                int          w;
                exp_t        e;
                if (ops < 16) begin
                    // Fill the working window so every later read has known data.
                    wen[3] = 1'b0; add[3] = BASE + 32'h100 + 32'(4 * ops);
                    wdata[3] = $urandom; be[3] = 4'hF;
                end else begin
                    k   = int'($urandom_range(15));
                    sel = int'($urandom_range(7));
                    wen[3]   = 1'($urandom_range(1));
                    wdata[3] = $urandom;
                    be[3]    = 4'($urandom_range(15));
                    if (sel == 0)
                        add[3] = k[0] ? BASE - 32'(4 * (k + 1)) : BASE + 32'h1000 + 32'(4 * k);
                    else
                        add[3] = BASE + 32'h100 + 32'(4 * k);
                end
                w     = int'((add[3] - BASE) >> 2) & 1023;
                e.due = cyc + 2;
                e.opc = !in_range(add[3]);
                e.rdata = 32'h0;
                if (in_range(add[3])) begin
                    if (wen[3]) begin
                        e.rdata = mdl[w];
                    end else begin
                        for (int l = 0; l < 4; l++)
                            if (be[3][l]) mdl[w][8*l +: 8] = wdata[3][8*l +: 8];
                    end
                end
                exp_q.push_back(e);
                ops++;
                grants++;
                $display("txn d #%0d cyc=%0d %s addr=%h wdata=%h be=%h exp_rdata=%h exp_opc=%0d",
                         ops, cyc, wen[3] ? "rd" : "wr", add[3], wdata[3], be[3], e.rdata, e.opc);
            end
            sample();
            check($sformatf("st_gnt_c%0d", cyc), gnt[3], issue);
            if (rv[3]) rvs++;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                check($sformatf("st_rv_c%0d", cyc), rv[3], 1);
                check($sformatf("st_rdata_c%0d", cyc), rdata[3], exp_q[0].rdata);
                check($sformatf("st_opc_c%0d", cyc), opc[3], exp_q[0].opc);
                void'(exp_q.pop_front());
            end else begin
                check($sformatf("st_rv_idle_c%0d", cyc), rv[3], 0);
            end
        end
        check("st_all_issued", 32'(ops), 80);
        check("st_drained", 32'(exp_q.size()), 0);
        check("st_rv_count", 32'(rvs), 32'(grants));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
